// File: rtl/base_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// base_ram_arbiter_if
// Bundle of every bus signal around the base RAM arbiter. It groups the
// two CPU-side request ports and the external SRAM pins.
//
//   Fetch port : if_req, if_addr -> if_data, if_ack
//   Data port  : mem_req, mem_we_n, mem_addr, mem_wdata, mem_be_n
//                -> mem_rdata, mem_ack
//   Pipeline   : stall_o
//   SRAM pins  : sram_addr, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n,
//                sram_data_o, sram_data_oe -> pins; sram_data_i <- pins
//
// Modports:
//   slave  - the arbiter's view (it takes requests and drives the SRAM)
//   master - the CPU/SRAM environment's view
// ---------------------------------------------------------------------------
interface base_ram_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_ack;

    logic        mem_req;
    logic        mem_we_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be_n;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stall_o;

    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [31:0] sram_data_o;
    logic        sram_data_oe;
    logic [31:0] sram_data_i;

    modport slave (
        input  if_req, if_addr,
        output if_data, if_ack,
        input  mem_req, mem_we_n, mem_addr, mem_wdata, mem_be_n,
        output mem_rdata, mem_ack,
        output stall_o,
        output sram_addr, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n,
        output sram_data_o, sram_data_oe,
        input  sram_data_i
    );

    modport master (
        output if_req, if_addr,
        input  if_data, if_ack,
        output mem_req, mem_we_n, mem_addr, mem_wdata, mem_be_n,
        input  mem_rdata, mem_ack,
        input  stall_o,
        input  sram_addr, sram_be_n, sram_ce_n, sram_oe_n, sram_we_n,
        input  sram_data_o, sram_data_oe,
        output sram_data_i
    );

endinterface

// File: rtl/base_ram_arbiter.sv
// ---------------------------------------------------------------------------
// base_ram_arbiter
// Shares one asynchronous 32-bit SRAM between an instruction-fetch port and
// a data port. Only one access is in flight at a time. When both ports
// request together, the port that was not granted last wins.
//
// Ports:
//   clk_50M  - sole clock, rising edge
//   rst_n    - asynchronous active-low reset
//   bus      - base_ram_arbiter_if.slave (request ports, stall, SRAM pins)
//
// Parameters:
//   RD_WAIT  - cycles the read strobe is held before data capture (1..15)
//   WR_PULSE - cycles sram_we_n is held low per write (1..15)
// ---------------------------------------------------------------------------
module base_ram_arbiter #(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input logic              clk_50M,
    input logic              rst_n,
    base_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // The wait counter counts down to zero, so it is loaded with n-1
    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        gnt_mem;
    logic        last_mem;

    logic [31:0] if_data_r;
    logic        if_ack_r;
    logic [31:0] mem_rdata_r;
    logic        mem_ack_r;

    logic [19:0] sram_addr_r;
    logic [3:0]  sram_be_n_r;
    logic        sram_ce_n_r;
    logic        sram_oe_n_r;
    logic        sram_we_n_r;
    logic [31:0] sram_data_o_r;
    logic        sram_data_oe_r;

    logic        pick_mem;
    logic        mem_in_range;
    logic        unused_addr_bits;

    // The SRAM window is 0x80000000..0x803FFFFF, i.e. the top ten address
    // bits equal 0x200. Anything else is answered without touching the SRAM.
    assign mem_in_range = (bus.mem_addr[31:22] == 10'h200);

    // Round robin: the data port wins unless it was the last one served
    // while the fetch port is also waiting.
    assign pick_mem = bus.mem_req && (!bus.if_req || !last_mem);

    // Only word address bits reach the SRAM
    assign unused_addr_bits = ^{bus.if_addr[31:22], bus.if_addr[1:0], bus.mem_addr[1:0]};

    // Main controller: every SRAM pin and every ack is a registered output,
    // set up on the transition into the state where it must be valid.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wait_cnt       <= 4'd0;
            gnt_mem        <= 1'b0;
            last_mem       <= 1'b0;
            if_data_r      <= 32'd0;
            if_ack_r       <= 1'b0;
            mem_rdata_r    <= 32'd0;
            mem_ack_r      <= 1'b0;
            sram_addr_r    <= 20'd0;
            sram_be_n_r    <= 4'hF;
            sram_ce_n_r    <= 1'b1;
            sram_oe_n_r    <= 1'b1;
            sram_we_n_r    <= 1'b1;
            sram_data_o_r  <= 32'd0;
            sram_data_oe_r <= 1'b0;
        end else begin
            if_ack_r  <= 1'b0;
            mem_ack_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.mem_req) begin
                        gnt_mem  <= pick_mem;
                        last_mem <= pick_mem;
                        if (!pick_mem) begin
                            sram_addr_r <= bus.if_addr[21:2];
                            sram_be_n_r <= 4'h0;
                            sram_ce_n_r <= 1'b0;
                            sram_oe_n_r <= 1'b0;
                            wait_cnt    <= RD_LOAD;
                            state       <= READ;
                        end else if (!mem_in_range) begin
                            // Out-of-window access: reads return zero and
                            // writes are dropped, acked on the next cycle
                            mem_rdata_r <= 32'd0;
                            mem_ack_r   <= 1'b1;
                            state       <= DONE;
                        end else if (bus.mem_we_n) begin
                            sram_addr_r <= bus.mem_addr[21:2];
                            sram_be_n_r <= bus.mem_be_n;
                            sram_ce_n_r <= 1'b0;
                            sram_oe_n_r <= 1'b0;
                            wait_cnt    <= RD_LOAD;
                            state       <= READ;
                        end else begin
                            sram_addr_r    <= bus.mem_addr[21:2];
                            sram_be_n_r    <= bus.mem_be_n;
                            sram_ce_n_r    <= 1'b0;
                            sram_we_n_r    <= 1'b0;
                            sram_data_o_r  <= bus.mem_wdata;
                            sram_data_oe_r <= 1'b1;
                            wait_cnt       <= WR_LOAD;
                            state          <= WRITE;
                        end
                    end
                end

                READ: begin
                    if (wait_cnt == 4'd0) begin
                        if (gnt_mem) begin
                            mem_rdata_r <= bus.sram_data_i;
                            mem_ack_r   <= 1'b1;
                        end else begin
                            if_data_r <= bus.sram_data_i;
                            if_ack_r  <= 1'b1;
                        end
                        sram_ce_n_r <= 1'b1;
                        sram_oe_n_r <= 1'b1;
                        sram_be_n_r <= 4'hF;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                WRITE: begin
                    // Raising we_n first while chip enable, address and data
                    // stay put gives the SRAM its write hold time in DONE
                    if (wait_cnt == 4'd0) begin
                        sram_we_n_r <= 1'b1;
                        mem_ack_r   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                DONE: begin
                    sram_ce_n_r    <= 1'b1;
                    sram_oe_n_r    <= 1'b1;
                    sram_we_n_r    <= 1'b1;
                    sram_be_n_r    <= 4'hF;
                    sram_data_oe_r <= 1'b0;
                    state          <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.if_data      = if_data_r;
    assign bus.if_ack       = if_ack_r;
    assign bus.mem_rdata    = mem_rdata_r;
    assign bus.mem_ack      = mem_ack_r;
    assign bus.sram_addr    = sram_addr_r;
    assign bus.sram_be_n    = sram_be_n_r;
    assign bus.sram_ce_n    = sram_ce_n_r;
    assign bus.sram_oe_n    = sram_oe_n_r;
    assign bus.sram_we_n    = sram_we_n_r;
    assign bus.sram_data_o  = sram_data_o_r;
    assign bus.sram_data_oe = sram_data_oe_r;

    // Stall for as long as any port has an outstanding request
    assign bus.stall_o = (bus.if_req & ~if_ack_r) | (bus.mem_req & ~mem_ack_r);

endmodule

// File: tb/tb_base_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_base_ram_arbiter
// Directed bench for base_ram_arbiter with a small behavioural SRAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_base_ram_arbiter;

    logic clk;
    logic rst_n;

    base_ram_arbiter_if bus ();

    base_ram_arbiter #(
        .RD_WAIT  (2),
        .WR_PULSE (2)
    ) dut (
        .clk_50M (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int total;
    int bad;

    // 64-word SRAM model: asynchronous read, byte-masked write on each
    // rising edge that sees chip enable and write enable low
    logic [31:0] sramMem [0:63];
    bit          modelReady = 1'b0;
    logic [5:0]  sramIdx;
    logic        unused_hiAddr;

    assign sramIdx         = bus.sram_addr[5:0];
    assign unused_hiAddr   = ^bus.sram_addr[19:6];
    assign bus.sram_data_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? sramMem[sramIdx] : 32'hFFFF_FFFF;

    always @(posedge clk) begin
        if (!modelReady) begin
            for (int i = 0; i < 64; i++) sramMem[i] <= 32'd0;
            sramMem[4]  <= 32'h1234_5678;
            sramMem[8]  <= 32'hCAFE_F00D;
            modelReady  <= 1'b1;
        end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!bus.sram_be_n[b]) sramMem[sramIdx][8*b +: 8] <= bus.sram_data_o[8*b +: 8];
        end
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Per-transaction observations recorded by applyStimulus
    int          cycles;
    int          ceLow;
    int          weLow;
    int          stallBad;
    logic [31:0] gotData;
    logic [19:0] firstAddr;
    logic [3:0]  beDuringWrite;
    logic        doneCe;
    logic        doneWe;
    logic        doneOe;
    logic        doneDataOe;
    logic [3:0]  doneBe;
    logic [31:0] doneDataO;
    logic        stallAtAck;

    // Observations recorded by tieRun
    int          ifAt;
    int          memAt;
    logic [31:0] tieIfData;
    logic [31:0] tieMemData;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One request on a single port; returns after the ack and one idle cycle
    task automatic applyStimulus(input bit isMem, input bit weN, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] beN);
        bit gotAck;
        gotAck = 1'b0;
        cycles = 0; ceLow = 0; weLow = 0; stallBad = 0;
        beDuringWrite = 4'hx;
        if (isMem) begin
            bus.mem_we_n  = weN;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
            bus.mem_be_n  = beN;
            bus.mem_req   = 1'b1;
        end else begin
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end
        while (!gotAck && cycles < 20) begin
            tick();
            cycles++;
            if (cycles == 1) firstAddr = bus.sram_addr;
            if (isMem ? bus.mem_ack : bus.if_ack) begin
                gotAck     = 1'b1;
                gotData    = isMem ? bus.mem_rdata : bus.if_data;
                doneCe     = bus.sram_ce_n;
                doneWe     = bus.sram_we_n;
                doneOe     = bus.sram_oe_n;
                doneDataOe = bus.sram_data_oe;
                doneBe     = bus.sram_be_n;
                doneDataO  = bus.sram_data_o;
                stallAtAck = bus.stall_o;
            end else begin
                if (!bus.sram_ce_n) ceLow++;
                if (!bus.sram_we_n) begin
                    weLow++;
                    beDuringWrite = bus.sram_be_n;
                end
                if (bus.stall_o !== 1'b1) stallBad++;
            end
        end
        if (!gotAck) checkOutput("ack_timeout", 32'd0, 32'd1);
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        tick();
    endtask

    // Both ports request a read in the same cycle; records when each acks
    task automatic tieRun(input logic [31:0] ifA, input logic [31:0] memA);
        int n;
        n = 0; ifAt = 0; memAt = 0;
        bus.if_addr  = ifA;
        bus.mem_addr = memA;
        bus.mem_we_n = 1'b1;
        bus.mem_be_n = 4'h0;
        bus.if_req   = 1'b1;
        bus.mem_req  = 1'b1;
        while ((ifAt == 0 || memAt == 0) && n < 30) begin
            tick();
            n++;
            if (bus.mem_ack && memAt == 0) begin
                memAt       = n;
                tieMemData  = bus.mem_rdata;
                bus.mem_req = 1'b0;
            end
            if (bus.if_ack && ifAt == 0) begin
                ifAt       = n;
                tieIfData  = bus.if_data;
                bus.if_req = 1'b0;
            end
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.mem_req   = 1'b0;
        bus.mem_we_n  = 1'b1;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_be_n  = 4'hF;

        // Reset state
        tick(); tick();
        checkOutput("rst_if_ack",    32'(bus.if_ack),       32'd0);
        checkOutput("rst_mem_ack",   32'(bus.mem_ack),      32'd0);
        checkOutput("rst_if_data",   bus.if_data,           32'd0);
        checkOutput("rst_mem_rdata", bus.mem_rdata,         32'd0);
        checkOutput("rst_ce_n",      32'(bus.sram_ce_n),    32'd1);
        checkOutput("rst_oe_n",      32'(bus.sram_oe_n),    32'd1);
        checkOutput("rst_we_n",      32'(bus.sram_we_n),    32'd1);
        checkOutput("rst_be_n",      32'(bus.sram_be_n),    32'hF);
        checkOutput("rst_data_oe",   32'(bus.sram_data_oe), 32'd0);
        checkOutput("rst_stall",     32'(bus.stall_o),      32'd0);
        rst_n = 1'b1;
        tick();

        // Tie straight out of reset: data port first, fetch second
        tieRun(32'h8000_0020, 32'h8000_0010);
        checkOutput("tie1_mem_at",   32'(memAt), 32'd3);
        checkOutput("tie1_if_at",    32'(ifAt),  32'd7);
        checkOutput("tie1_mem_data", tieMemData, 32'h1234_5678);
        checkOutput("tie1_if_data",  tieIfData,  32'hCAFE_F00D);

        // Fetch only from word 4
        applyStimulus(1'b0, 1'b1, 32'h8000_0010, 32'd0, 4'h0);
        checkOutput("fetch_addr",     32'(firstAddr), 32'h0_0004);
        checkOutput("fetch_latency",  32'(cycles),    32'd3);
        checkOutput("fetch_data",     gotData,        32'h1234_5678);
        checkOutput("fetch_ce_cycles", 32'(ceLow),    32'd2);
        checkOutput("fetch_done_ce",  32'(doneCe),    32'd1);
        checkOutput("fetch_done_oe",  32'(doneOe),    32'd1);
        checkOutput("fetch_stall",    32'(stallBad),  32'd0);
        checkOutput("fetch_stall_ack", 32'(stallAtAck), 32'd0);

        // Last grant was the fetch port, so the data port wins this tie
        tieRun(32'h8000_0020, 32'h8000_0010);
        checkOutput("tie2_mem_at", 32'(memAt), 32'd3);
        checkOutput("tie2_if_at",  32'(ifAt),  32'd7);

        // Full-word write
        applyStimulus(1'b1, 1'b0, 32'h8000_0008, 32'hDEAD_BEEF, 4'h0);
        checkOutput("wr_latency",   32'(cycles),     32'd3);
        checkOutput("wr_we_cycles", 32'(weLow),      32'd2);
        checkOutput("wr_done_we",   32'(doneWe),     32'd1);
        checkOutput("wr_done_ce",   32'(doneCe),     32'd0);
        checkOutput("wr_done_oe",   32'(doneDataOe), 32'd1);
        checkOutput("wr_done_data", doneDataO,       32'hDEAD_BEEF);
        checkOutput("wr_addr",      32'(firstAddr),  32'h0_0002);
        checkOutput("wr_stall",     32'(stallBad),   32'd0);

        // Last grant was the data port, so fetch wins; mem reads the write back
        tieRun(32'h8000_0010, 32'h8000_0008);
        checkOutput("tie3_if_at",    32'(ifAt),  32'd3);
        checkOutput("tie3_mem_at",   32'(memAt), 32'd7);
        checkOutput("tie3_if_data",  tieIfData,  32'h1234_5678);
        checkOutput("readback_data", tieMemData, 32'hDEAD_BEEF);

        // Out-of-window read
        applyStimulus(1'b1, 1'b1, 32'h8040_0000, 32'd0, 4'h0);
        checkOutput("oor_latency", 32'(cycles), 32'd1);
        checkOutput("oor_ce",      32'(ceLow),  32'd0);
        checkOutput("oor_ce_done", 32'(doneCe), 32'd1);
        checkOutput("oor_data",    gotData,     32'd0);

        // Single-byte write then read back
        applyStimulus(1'b1, 1'b0, 32'h8000_0008, 32'h1111_11AA, 4'hE);
        checkOutput("bw_latency", 32'(cycles),        32'd3);
        checkOutput("bw_be_wr",   32'(beDuringWrite), 32'hE);
        checkOutput("bw_be_done", 32'(doneBe),        32'hE);
        checkOutput("bw_stall",   32'(stallBad),      32'd0);
        applyStimulus(1'b1, 1'b1, 32'h8000_0008, 32'd0, 4'h0);
        checkOutput("bw_readback", gotData, 32'hDEAD_BEAA);

        // Reset in the middle of a write
        bus.mem_we_n  = 1'b0;
        bus.mem_addr  = 32'h8000_0010;
        bus.mem_wdata = 32'h5555_5555;
        bus.mem_be_n  = 4'h0;
        bus.mem_req   = 1'b1;
        tick();
        checkOutput("abort_we_low", 32'(bus.sram_we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_we_n",    32'(bus.sram_we_n),    32'd1);
        checkOutput("abort_data_oe", 32'(bus.sram_data_oe), 32'd0);
        checkOutput("abort_ce_n",    32'(bus.sram_ce_n),    32'd1);
        bus.mem_req = 1'b0;
        tick();
        checkOutput("abort_no_ack",  32'(bus.mem_ack),   32'd0);
        checkOutput("abort_rdata",   bus.mem_rdata,      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("abort_no_ack2", 32'(bus.mem_ack),   32'd0);
        applyStimulus(1'b1, 1'b0, 32'h8000_0010, 32'h5555_5555, 4'h0);
        checkOutput("reissue_latency", 32'(cycles), 32'd3);
        applyStimulus(1'b0, 1'b1, 32'h8000_0010, 32'd0, 4'h0);
        checkOutput("reissue_readback", gotData, 32'h5555_5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/base_ram_arbiter.md
BASE_RAM_ARBITER -- requirements
Module: base_ram_arbiter

Interface
REQ-001 Parameter RD_WAIT, default 2, number of cycles the SRAM read strobe is held before data capture (legal range 1..15).
REQ-002 Parameter WR_PULSE, default 2, number of cycles sram_we_n is held low per write (legal range 1..15).
REQ-003 clk_50M  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  instruction-fetch request; held high until if_ack.
REQ-006 if_addr  in  32  fetch byte address; word index taken from [21:2].
REQ-007 if_data  out  32  fetched word; valid while if_ack is high.
REQ-008 if_ack  out  1  one-cycle fetch-complete pulse.
REQ-009 mem_req  in  1  data-port request; held high until mem_ack.
REQ-010 mem_we_n  in  1  0 = write, 1 = read.
REQ-011 mem_addr  in  32  data byte address.
REQ-012 mem_wdata  in  32  write data.
REQ-013 mem_be_n  in  4  byte enables, active low.
REQ-014 mem_rdata  out  32  read data; valid while mem_ack is high.
REQ-015 mem_ack  out  1  one-cycle data-complete pulse.
REQ-016 stall_o  out  1  pipeline stall request.
REQ-017 sram_addr  out  20; sram_be_n  out  4; sram_ce_n, sram_oe_n, sram_we_n  out  1 each; all registered.
REQ-018 sram_data_o  out  32, sram_data_oe  out  1 (tristate enable, applied by the pad wrapper), sram_data_i  in  32.

Function
REQ-019 FSM states: IDLE, READ, WRITE, DONE.
REQ-020 Requests are sampled only in IDLE; inputs must stay stable from request until ack; requests are never sampled in DONE.
REQ-021 Arbitration: only one pending -> grant it; both pending -> grant the port not granted last (round robin); last-grant register resets to "fetch", so mem wins the first tie.
REQ-022 Fetch always reads: grant -> READ, sram_addr=if_addr[21:2], sram_be_n=0000.
REQ-023 Mem grant with mem_addr in 0x80000000..0x803FFFFF -> READ (mem_we_n=1) or WRITE (mem_we_n=0), sram_addr=mem_addr[21:2], sram_be_n=mem_be_n.
REQ-024 Mem grant with mem_addr out of range -> straight to DONE, no SRAM strobe, mem_rdata=0, write discarded.
REQ-025 READ: ce_n=0, oe_n=0, we_n=1, data_oe=0 for exactly RD_WAIT cycles; on the last cycle sram_data_i is captured into the granted port's data register; then DONE.
REQ-026 WRITE: ce_n=0, oe_n=1, we_n=0, data_oe=1, sram_data_o=mem_wdata for exactly WR_PULSE cycles; then DONE.
REQ-027 DONE lasts one cycle: granted port's ack=1; after a write, we_n=1 while ce_n=0, data_oe=1 and address/data remain held (hold time); after a read, all strobes inactive; then IDLE.
REQ-028 Latency request-seen-in-IDLE to ack: RD_WAIT+1 cycles for reads, WR_PULSE+1 for writes, 1 for out-of-range.
REQ-029 IDLE: ce_n=oe_n=we_n=1, be_n=1111, data_oe=0.
REQ-030 Wait counter is 4 bits, loaded with parameter-1 on entry, decremented, and exits at 0; no wrap.
REQ-031 stall_o = (if_req & ~if_ack) | (mem_req & ~mem_ack), combinational.
REQ-032 if_data/mem_rdata hold their last captured value until the next capture for that port.
REQ-033 A request rising in the same cycle another transaction ends (DONE) is accepted in the following IDLE cycle.

Reset
REQ-034 rst_n low forces IDLE immediately: acks 0, data registers 0, strobes inactive, be_n=1111, data_oe=0, last-grant=fetch.
REQ-035 Reset during READ/WRITE aborts the transaction with no ack; the first request after release restarts from IDLE.

Verification
REQ-036 Fetch only, if_addr=0x80000010, SRAM word 4 = 0x12345678 -> sram_addr=0x00004, if_ack 3 cycles after IDLE sample, if_data=0x12345678.
REQ-037 Mem write addr 0x80000008, wdata 0xDEADBEEF, be_n=0000 -> we_n low 2 cycles, data held through DONE, mem_ack 3 cycles after sample; readback returns 0xDEADBEEF.
REQ-038 if_req and mem_req rise together from reset -> mem served first, fetch second; the next tie goes to mem again only after a fetch grant.
REQ-039 mem_addr=0x80400000 read -> no sram_ce_n activity, mem_ack 1 cycle after sample, mem_rdata=0.
REQ-040 rst_n pulsed low mid-WRITE -> we_n=1 and data_oe=0 asynchronously, no mem_ack; a reissued request completes normally.
REQ-041 Byte write be_n=1110 -> sram_be_n=1110 during WRITE and DONE; stall_o high from request until ack on every transaction.
